timer6: RTL and testbench
=========================

TIMER6 -- requirements
Module: timer6

Interface
REQ-001 Parameter CLKS_PER_MS, default 100000, clk_i cycles per millisecond tick; benches use 1.
REQ-002 clk_i  input  1  system clock, all state on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  start/pause button, level, asynchronous to clk_i.
REQ-005 left_i  input  1  cursor one digit toward more significant.
REQ-006 right_i  input  1  cursor one digit toward less significant.
REQ-007 up_i  input  1  increment selected digit.
REQ-008 down_i  input  1  decrement selected digit.
REQ-009 ml_o  output  10  milliseconds remaining, 0..999.
REQ-010 sec_o  output  6  seconds remaining, 0..59.
REQ-011 min_o  output  6  minutes remaining, 0..59.
REQ-012 hour_o  output  6  hours remaining, 0..23.
REQ-013 digitp  output  3  cursor: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hour ones, 5 hour tens; 6..7 never driven.

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer and rising-edge detector; one press = one single-cycle event; event at most 3 cycles after the level is sampled high; pulses not spanning a clk_i rising edge may be lost.
REQ-015 States SHALL be SET and RUN; reset enters SET.
REQ-016 Same-cycle event priority: start > left > right > up > down; lower ones dropped.
REQ-017 SET: left SHALL do digitp = (digitp==5) ? 0 : digitp+1; right SHALL do digitp = (digitp==0) ? 5 : digitp-1.
REQ-018 SET: up SHALL add the digit weight (1 for even digitp, 10 for odd) to its field, saturating at field max (59 sec/min, 23 hour).
REQ-019 SET: down SHALL subtract the weight, saturating at 0.
REQ-020 SET: editing SHALL NOT change ml_o.
REQ-021 SET: start SHALL enter RUN only if total time (hour,min,sec,ml) is nonzero; else ignored.
REQ-022 RUN: a prescaler SHALL emit one tick every CLKS_PER_MS cycles, first tick CLKS_PER_MS cycles after entering RUN.
REQ-023 Tick SHALL decrement the time as a mixed-radix counter: ml 0 -> 999 with borrow from sec, sec 0 -> 59 with borrow from min, min 0 -> 59 with borrow from hour.
REQ-024 On the tick that makes total time zero, outputs SHALL read 0:0:0.000 and state SHALL return to SET the same edge.
REQ-025 RUN: start SHALL pause (enter SET, keep time, clear prescaler); next start resumes from the held value.
REQ-026 RUN: left/right/up/down SHALL be ignored; digitp holds.
REQ-027 Outputs SHALL be registered, direct from state, no combinational path from inputs.

Reset
REQ-028 reset_i high SHALL immediately force ml_o, sec_o, min_o, hour_o, digitp to 0, state SET, prescaler and synchronizer/edge flops to 0, including mid-RUN.
REQ-029 After reset_i falls, a button already high SHALL NOT generate an event until released and pressed again.

Structure
REQ-030 Shared package SHALL hold field maxima (999, 59, 59, 23), digit-index constants 0..5, and the SET/RUN state encoding.
REQ-031 One sub-module, btn_edge (synchronizer + rising-edge detect), SHALL be instantiated five times; the rest is one module.

Verification (CLKS_PER_MS=1, presses held 3 cycles)
REQ-032 Reset, up x2 -> sec_o=2, digitp=0; right x1 -> digitp=5; left x2 -> digitp=1.
REQ-033 From 0:0:0, digitp=1, up x7 -> sec_o=59 (saturated at 59, not 60); down x7 from sec_o=5 at digitp=0 -> sec_o=0.
REQ-034 Set 0:1:0 (digitp=2, up), start -> first tick 0:0:59.999; after 60000 ticks 0:0:0.000, state SET, further ticks change nothing.
REQ-035 Run from 0:0:2, start after 10 ticks -> holds 0:0:1.990; up ignored; start -> resumes from 1.990.
REQ-036 Reset pulse mid-RUN -> all outputs 0 asynchronously, digitp=0; start with zero time -> stays SET, outputs 0.
REQ-037 start and up asserted the same cycle in SET with nonzero time -> RUN entered, field value unchanged.

Source files
------------

// File: rtl/timer6_pkg.sv
// ---------------------------------------------------------------------------
// timer6_pkg
// Shared definitions for the timer6 countdown timer:
//   - field maxima for milliseconds, seconds, minutes and hours
//   - cursor (digit index) constants, 0 = seconds ones .. 5 = hours tens
//   - SET/RUN state encoding
//   - saturating add/subtract helpers used by the digit editor
// ---------------------------------------------------------------------------
package timer6_pkg;

    localparam logic [9:0] ML_MAX   = 10'd999;
    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] HOUR_MAX = 6'd23;

    localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
    localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
    localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
    localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
    localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
    localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

    typedef enum logic {
        ST_SET = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    // Odd cursor positions are tens digits.
    function automatic logic [5:0] digit_weight(input logic [2:0] d);
        return d[0] ? 6'd10 : 6'd1;
    endfunction

    function automatic logic [5:0] sat_add(input logic [5:0] v,
                                           input logic [5:0] w,
                                           input logic [5:0] lim);
        logic [6:0] sum;
        sum = {1'b0, v} + {1'b0, w};
        return (sum > {1'b0, lim}) ? lim : sum[5:0];
    endfunction

    function automatic logic [5:0] sat_sub(input logic [5:0] v,
                                           input logic [5:0] w);
        return (v < w) ? 6'd0 : (v - w);
    endfunction

endpackage

// File: rtl/timer6_btn_edge.sv
// ---------------------------------------------------------------------------
// btn_edge
// Two-flop synchronizer followed by a rising-edge detector for one push
// button. One press produces one single-cycle event.
//   clk_i    system clock
//   reset_i  asynchronous active-high reset
//   btn_i    raw button level, asynchronous to clk_i
//   evt_o    single-cycle press event
// ---------------------------------------------------------------------------
module btn_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic evt_o
);

    logic sync1;
    logic sync2;
    logic prev;
    logic fill1;
    logic fill2;
    logic armed;

    // fill1/fill2 mark the point at which sync2 holds a real post-reset
    // sample. The detector only arms once that sample shows the button
    // released, so a button held through reset release gives no event.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            fill1 <= 1'b0;
            fill2 <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync1 <= btn_i;
            sync2 <= sync1;
            prev  <= sync2;
            fill1 <= 1'b1;
            fill2 <= fill1;
            if (fill2 && !sync2) begin
                armed <= 1'b1;
            end
        end
    end

    assign evt_o = sync2 & ~prev & armed;

endmodule

// File: rtl/timer6.sv
// ---------------------------------------------------------------------------
// timer6
// Settable countdown timer (hh:mm:ss.mmm) with a cursor-based digit editor.
// In SET the buttons move the cursor and edit the selected digit; start
// enters RUN when the time is nonzero. In RUN a prescaler produces one
// millisecond tick every CLKS_PER_MS cycles and the time counts down,
// returning to SET on reaching zero or when start is pressed again.
//   clk_i    system clock
//   reset_i  asynchronous active-high reset
//   start_i  start/pause button (level)
//   left_i   cursor toward more significant digit
//   right_i  cursor toward less significant digit
//   up_i     increment selected digit
//   down_i   decrement selected digit
//   ml_o     milliseconds remaining, 0..999
//   sec_o    seconds remaining, 0..59
//   min_o    minutes remaining, 0..59
//   hour_o   hours remaining, 0..23
//   digitp   cursor position, 0..5
// ---------------------------------------------------------------------------
module timer6
    import timer6_pkg::*;
#(
    parameter int unsigned CLKS_PER_MS = 100000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       left_i,
    input  logic       right_i,
    input  logic       up_i,
    input  logic       down_i,
    output logic [9:0] ml_o,
    output logic [5:0] sec_o,
    output logic [5:0] min_o,
    output logic [5:0] hour_o,
    output logic [2:0] digitp
);

    localparam int unsigned PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);

    state_t        state_q;
    logic [PW-1:0] presc_q;

    logic start_ev;
    logic left_ev;
    logic right_ev;
    logic up_ev;
    logic down_ev;

    btn_edge u_start (.clk_i(clk_i), .reset_i(reset_i), .btn_i(start_i), .evt_o(start_ev));
    btn_edge u_left  (.clk_i(clk_i), .reset_i(reset_i), .btn_i(left_i),  .evt_o(left_ev));
    btn_edge u_right (.clk_i(clk_i), .reset_i(reset_i), .btn_i(right_i), .evt_o(right_ev));
    btn_edge u_up    (.clk_i(clk_i), .reset_i(reset_i), .btn_i(up_i),    .evt_o(up_ev));
    btn_edge u_down  (.clk_i(clk_i), .reset_i(reset_i), .btn_i(down_i),  .evt_o(down_ev));

    logic       tick;
    logic       time_nonzero;
    logic       last_ms;

    logic [5:0] weight;
    logic [5:0] sec_edit;
    logic [5:0] min_edit;
    logic [5:0] hour_edit;

    logic [9:0] ml_dec;
    logic [5:0] sec_dec;
    logic [5:0] min_dec;
    logic [5:0] hour_dec;

    assign tick         = (presc_q == PRESC_LAST);
    assign time_nonzero = |{hour_o, min_o, sec_o, ml_o};
    // One millisecond left: the coming tick brings the total to zero.
    assign last_ms      = (ml_o == 10'd1) && (sec_o == 6'd0) &&
                          (min_o == 6'd0) && (hour_o == 6'd0);

    // Digit editor: up takes precedence over down when both fire, so the
    // direction is chosen from up_ev alone.
    always_comb begin
        weight    = digit_weight(digitp);
        sec_edit  = sec_o;
        min_edit  = min_o;
        hour_edit = hour_o;
        case (digitp)
            DIG_SEC_ONES, DIG_SEC_TENS:
                sec_edit  = up_ev ? sat_add(sec_o, weight, SEC_MAX)
                                  : sat_sub(sec_o, weight);
            DIG_MIN_ONES, DIG_MIN_TENS:
                min_edit  = up_ev ? sat_add(min_o, weight, MIN_MAX)
                                  : sat_sub(min_o, weight);
            DIG_HOUR_ONES, DIG_HOUR_TENS:
                hour_edit = up_ev ? sat_add(hour_o, weight, HOUR_MAX)
                                  : sat_sub(hour_o, weight);
            default: ;
        endcase
    end

    // Mixed-radix decrement with borrow chain ml -> sec -> min -> hour.
    always_comb begin
        ml_dec   = ml_o;
        sec_dec  = sec_o;
        min_dec  = min_o;
        hour_dec = hour_o;
        if (ml_o != 10'd0) begin
            ml_dec = ml_o - 10'd1;
        end else begin
            ml_dec = ML_MAX;
            if (sec_o != 6'd0) begin
                sec_dec = sec_o - 6'd1;
            end else begin
                sec_dec = SEC_MAX;
                if (min_o != 6'd0) begin
                    min_dec = min_o - 6'd1;
                end else begin
                    min_dec  = MIN_MAX;
                    hour_dec = hour_o - 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_SET;
            presc_q <= '0;
            digitp  <= DIG_SEC_ONES;
            ml_o    <= '0;
            sec_o   <= '0;
            min_o   <= '0;
            hour_o  <= '0;
        end else begin
            case (state_q)
                ST_SET: begin
                    presc_q <= '0;
                    if (start_ev) begin
                        if (time_nonzero) begin
                            state_q <= ST_RUN;
                        end
                    end else if (left_ev) begin
                        digitp <= (digitp == DIG_HOUR_TENS) ? DIG_SEC_ONES : digitp + 3'd1;
                    end else if (right_ev) begin
                        digitp <= (digitp == DIG_SEC_ONES) ? DIG_HOUR_TENS : digitp - 3'd1;
                    end else if (up_ev || down_ev) begin
                        sec_o  <= sec_edit;
                        min_o  <= min_edit;
                        hour_o <= hour_edit;
                    end
                end
                ST_RUN: begin
                    if (start_ev) begin
                        // Pause: a tick landing on the same edge is dropped.
                        state_q <= ST_SET;
                        presc_q <= '0;
                    end else begin
                        presc_q <= tick ? '0 : presc_q + PW'(1);
                        if (tick) begin
                            ml_o   <= ml_dec;
                            sec_o  <= sec_dec;
                            min_o  <= min_dec;
                            hour_o <= hour_dec;
                            if (last_ms) begin
                                state_q <= ST_SET;
                            end
                        end
                    end
                end
                default: state_q <= ST_SET;
            endcase
        end
    end

endmodule

// File: tb/tb_timer6.sv
// ---------------------------------------------------------------------------
// tb_timer6
// Directed bench for timer6 with CLKS_PER_MS = 1. Buttons are driven on the
// falling clock edge and held for three cycles; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_timer6;

    localparam int B_START = 0;
    localparam int B_LEFT  = 1;
    localparam int B_RIGHT = 2;
    localparam int B_UP    = 3;
    localparam int B_DOWN  = 4;

    logic       clk_i   = 1'b0;
    logic       reset_i = 1'b1;
    logic       start_i = 1'b0;
    logic       left_i  = 1'b0;
    logic       right_i = 1'b0;
    logic       up_i    = 1'b0;
    logic       down_i  = 1'b0;
    logic [9:0] ml_o;
    logic [5:0] sec_o;
    logic [5:0] min_o;
    logic [5:0] hour_o;
    logic [2:0] digitp;

    int tests = 0;
    int fails = 0;

    timer6 #(.CLKS_PER_MS(1)) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .start_i(start_i),
        .left_i (left_i),
        .right_i(right_i),
        .up_i   (up_i),
        .down_i (down_i),
        .ml_o   (ml_o),
        .sec_o  (sec_o),
        .min_o  (min_o),
        .hour_o (hour_o),
        .digitp (digitp)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m,
                            input int s, input int ms);
        chk({tag, ".hour"}, {26'd0, hour_o}, h);
        chk({tag, ".min"},  {26'd0, min_o},  m);
        chk({tag, ".sec"},  {26'd0, sec_o},  s);
        chk({tag, ".ml"},   {22'd0, ml_o},   ms);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_START: start_i = v;
            B_LEFT:  left_i  = v;
            B_RIGHT: right_i = v;
            B_UP:    up_i    = v;
            default: down_i  = v;
        endcase
    endtask

    // Raise on a falling edge, hold across three rising edges, release,
    // then wait 'settle' more falling edges.
    task automatic press(input int b, input int settle);
        set_btn(b, 1'b1);
        repeat (3) @(negedge clk_i);
        set_btn(b, 1'b0);
        repeat (settle) @(negedge clk_i);
    endtask

    task automatic press_n(input int b, input int n);
        for (int i = 0; i < n; i++) press(b, 3);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        repeat (5) @(negedge clk_i);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_i);
        chk_time("reset", 0, 0, 0, 0);
        chk("reset.digitp", {29'd0, digitp}, 0);
        reset_i = 1'b0;
        repeat (5) @(negedge clk_i);

        // Up twice, cursor moves with wrap
        press_n(B_UP, 2);
        chk("up2.sec", {26'd0, sec_o}, 2);
        chk("up2.digitp", {29'd0, digitp}, 0);
        press_n(B_RIGHT, 1);
        chk("right_wrap.digitp", {29'd0, digitp}, 5);
        press_n(B_LEFT, 2);
        chk("left2.digitp", {29'd0, digitp}, 1);

        // Tens saturation at 59, down saturation at 0
        do_reset();
        press_n(B_LEFT, 1);
        press_n(B_UP, 7);
        chk("sec_tens_sat", {26'd0, sec_o}, 59);
        do_reset();
        press_n(B_UP, 5);
        chk("sec_five", {26'd0, sec_o}, 5);
        press_n(B_DOWN, 7);
        chk("sec_down_sat", {26'd0, sec_o}, 0);
        press_n(B_LEFT, 5);
        chk("left5.digitp", {29'd0, digitp}, 5);
        press_n(B_UP, 3);
        chk("hour_sat", {26'd0, hour_o}, 23);
        press_n(B_RIGHT, 2);
        press_n(B_UP, 1);
        chk("min_tens_up", {26'd0, min_o}, 10);
        press_n(B_DOWN, 2);
        chk("min_tens_down", {26'd0, min_o}, 0);
        chk("hour_kept", {26'd0, hour_o}, 23);

        // One minute countdown to zero
        do_reset();
        press_n(B_LEFT, 2);
        press_n(B_UP, 1);
        chk_time("set_1min", 0, 1, 0, 0);
        press(B_START, 0);
        chk_time("run_entry", 0, 1, 0, 0);
        @(negedge clk_i);
        chk_time("first_tick", 0, 0, 59, 999);
        repeat (59999) @(negedge clk_i);
        chk_time("count_zero", 0, 0, 0, 0);
        repeat (5) @(negedge clk_i);
        chk_time("zero_hold", 0, 0, 0, 0);
        press_n(B_UP, 1);
        chk("back_in_set.min", {26'd0, min_o}, 1);

        // Pause after ten ticks, edits ignored while running, resume
        do_reset();
        press_n(B_UP, 2);
        press(B_START, 0);
        repeat (8) @(negedge clk_i);
        press(B_START, 0);
        chk_time("paused", 0, 0, 1, 990);
        repeat (4) @(negedge clk_i);
        chk_time("pause_hold", 0, 0, 1, 990);
        press(B_START, 0);
        chk_time("resume_entry", 0, 0, 1, 990);
        @(negedge clk_i);
        chk_time("resume_tick", 0, 0, 1, 989);
        press(B_UP, 0);
        chk_time("run_up_ignored", 0, 0, 1, 986);
        chk("run_digitp", {29'd0, digitp}, 0);

        // Asynchronous reset while running
        @(negedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        chk_time("async_reset", 0, 0, 0, 0);
        chk("async_reset.digitp", {29'd0, digitp}, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        repeat (5) @(negedge clk_i);
        press(B_START, 3);
        repeat (5) @(negedge clk_i);
        chk_time("start_zero_ignored", 0, 0, 0, 0);

        // start and up on the same cycle: start wins, up dropped
        press_n(B_UP, 1);
        chk("pre_combo.sec", {26'd0, sec_o}, 1);
        start_i = 1'b1;
        up_i    = 1'b1;
        repeat (3) @(negedge clk_i);
        start_i = 1'b0;
        up_i    = 1'b0;
        chk_time("combo_entry", 0, 0, 1, 0);
        @(negedge clk_i);
        chk_time("combo_tick", 0, 0, 0, 999);
        repeat (999) @(negedge clk_i);
        chk_time("combo_zero", 0, 0, 0, 0);

        // Button held through reset release gives no event
        reset_i = 1'b1;
        up_i    = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        repeat (6) @(negedge clk_i);
        chk("held_through_reset.sec", {26'd0, sec_o}, 0);
        up_i = 1'b0;
        repeat (3) @(negedge clk_i);
        press_n(B_UP, 1);
        chk("repress.sec", {26'd0, sec_o}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
